// File: rtl/verifier_io_loader.sv
// verifier_io_loader: streams tau coordinates then I/O values into register banks, starts
// verifier_compute_io and latches its result. Optional range check: VERIFIER_IO_LOADER_RANGECHK_EN.
module verifier_io_loader #(
  parameter int                 nValBits = 8,
  parameter int                 nValues  = 1 << nValBits,
  parameter int                 F_NBITS  = 64,
  parameter logic [F_NBITS-1:0] F_Q      = 64'hFFFF_FFFF_0000_0001
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          in_valid,
  input  logic [F_NBITS-1:0]            in_data,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [nValBits*F_NBITS-1:0]   tau_out,
  output logic [nValues*F_NBITS-1:0]    vals_out,
  output logic                          compute_en,
  input  logic                          compute_ready,
  input  logic [F_NBITS-1:0]            compute_result,
  output logic [F_NBITS-1:0]            result,
  output logic                          done,
  output logic                          err
);

  localparam int IDX_W = nValBits + 1;
  localparam logic [IDX_W-1:0] LAST_TAU = IDX_W'(nValBits - 1);
  localparam logic [IDX_W-1:0] LAST_VAL = IDX_W'(nValues - 1);

  if (nValues != (1 << nValBits)) begin : g_bad_nvalues
    $error("nValues is derived from nValBits and must not be overridden");
  end
  if (nValBits < 2) begin : g_bad_nvalbits
    $error("nValBits must be at least 2");
  end
  if (F_Q == '0) begin : g_bad_fq
    $error("F_Q must be nonzero");
  end

  typedef enum logic [2:0] {
    ST_TAU   = 3'd0,
    ST_VAL   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [F_NBITS-1:0] tau_q  [nValBits];
  logic [F_NBITS-1:0] vals_q [nValues];
  logic               accept;
  logic [F_NBITS-1:0] word;

  assign in_ready   = (state == ST_TAU) || (state == ST_VAL);
  assign compute_en = (state == ST_START);
  assign done       = (state == ST_DONE);
  // A flushed cycle drops the offered word.
  assign accept     = in_valid && in_ready && !flush;

`ifdef VERIFIER_IO_LOADER_RANGECHK_EN
  logic over;
  assign over = (in_data >= F_Q);
  assign word = over ? (in_data - F_Q) : in_data;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      err <= 1'b0;
    end else if (accept && over) begin
      err <= 1'b1;
    end
  end
`else
  assign word = in_data;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= ST_TAU;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        ST_TAU: begin
          if (flush) begin
            idx <= '0;
          end else if (accept) begin
            if (idx == LAST_TAU) begin
              state <= ST_VAL;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_VAL: begin
          if (flush) begin
            state <= ST_TAU;
            idx   <= '0;
          end else if (accept) begin
            if (idx == LAST_VAL) begin
              state <= ST_START;
              idx   <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        ST_START: state <= ST_WAIT;
        ST_WAIT: begin
          // Latch on the ready cycle so result is already valid while done is high.
          if (compute_ready) begin
            result <= compute_result;
            state  <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_TAU;
        default: begin
          state <= ST_TAU;
          idx   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int k = 0; k < nValBits; k++) tau_q[k] <= '0;
      for (int k = 0; k < nValues; k++)  vals_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < nValBits; k++) begin
        if (state == ST_TAU && idx == IDX_W'(k)) tau_q[k] <= word;
      end
      for (int k = 0; k < nValues; k++) begin
        if (state == ST_VAL && idx == IDX_W'(k)) vals_q[k] <= word;
      end
    end
  end

  for (genvar k = 0; k < nValBits; k++) begin : g_tau
    assign tau_out[k*F_NBITS +: F_NBITS] = tau_q[k];
  end
  for (genvar k = 0; k < nValues; k++) begin : g_vals
    assign vals_out[k*F_NBITS +: F_NBITS] = vals_q[k];
  end

endmodule

// File: tb/tb_verifier_io_loader.sv
// Bench for verifier_io_loader: directed loads against a behavioural model plus a
// downstream stub that evaluates the multilinear extension of the streamed words.
`timescale 1ns/1ps
module tb_verifier_io_loader;

  localparam int NB = 2;
  localparam int NV = 4;
  localparam int FW = 64;
  localparam logic [FW-1:0] Q = 64'hFFFF_FFFF_0000_0001;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic compute_ready = 1'b0;
  logic [FW-1:0] in_data = '0;
  logic [FW-1:0] compute_result = '0;
  logic in_ready, compute_en, done, err;
  logic [FW-1:0] result;
  logic [NB*FW-1:0] tau_out;
  logic [NV*FW-1:0] vals_out;

  int n_chk = 0;
  int n_fail = 0;
  int en_pulses = 0;

  verifier_io_loader #(.nValBits(NB), .F_NBITS(FW), .F_Q(Q)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .tau_out(tau_out), .vals_out(vals_out), .compute_en(compute_en),
    .compute_ready(compute_ready), .compute_result(compute_result), .result(result),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 loading, 1 start strobe, 2 waiting, 3 done.
  int m_phase;
  int m_cnt;
  logic [FW-1:0] m_tau [NB];
  logic [FW-1:0] m_vals [NV];
  logic [FW-1:0] m_result;
  logic m_err;

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_result = '0; m_err = 1'b0;
    for (int i = 0; i < NB; i++) m_tau[i] = '0;
    for (int i = 0; i < NV; i++) m_vals[i] = '0;
  endtask

  task automatic m_step();
    logic [FW-1:0] w;
    case (m_phase)
      0: begin
        if (flush) begin
          m_cnt = 0;
        end else if (in_valid) begin
          w = in_data;
`ifdef VERIFIER_IO_LOADER_RANGECHK_EN
          if (w >= Q) begin
            w = w - Q;
            m_err = 1'b1;
          end
`endif
          if (m_cnt < NB) m_tau[m_cnt] = w;
          else m_vals[m_cnt-NB] = w;
          m_cnt++;
          if (m_cnt == NB + NV) begin
            m_cnt = 0;
            m_phase = 1;
          end
        end
      end
      1: m_phase = 2;
      2: if (compute_ready) begin
        m_result = compute_result;
        m_phase = 3;
      end
      default: m_phase = 0;
    endcase
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) m_reset();
      else m_step();
    end
  end

  function automatic logic [511:0] flat_tau();
    logic [511:0] v = '0;
    for (int i = 0; i < NB; i++) v[i*FW +: FW] = m_tau[i];
    return v;
  endfunction

  function automatic logic [511:0] flat_vals();
    logic [511:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*FW +: FW] = m_vals[i];
    return v;
  endfunction

  // Multilinear extension of the model banks over GF(Q); bit j of the value index selects tau[j].
  function automatic logic [FW-1:0] mle();
    logic [127:0] acc, term, wt, tj;
    acc = '0;
    for (int i = 0; i < NV; i++) begin
      term = 128'(m_vals[i] % Q);
      for (int j = 0; j < NB; j++) begin
        tj = 128'(m_tau[j] % Q);
        wt = ((i >> j) & 1) != 0 ? tj : (128'(Q) + 128'd1 - tj) % 128'(Q);
        term = (term * wt) % 128'(Q);
      end
      acc = (acc + term) % 128'(Q);
    end
    return acc[FW-1:0];
  endfunction

  initial begin
    logic prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (compute_en && !prev_en) en_pulses++;
      prev_en = compute_en;
      chk("in_ready", in_ready, m_phase == 0);
      chk("compute_en", compute_en, m_phase == 1);
      chk("done", done, m_phase == 3);
      chk("result", result, m_result);
      chk("err", err, m_err);
      chk("tau_out", tau_out, flat_tau());
      chk("vals_out", vals_out, flat_vals());
    end
  end

  task automatic send(input logic [FW-1:0] w, input int gap);
    bit got = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data = w;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got no handshake, expected one within 50 cycles");
    end
  endtask

  task automatic run_load(input logic [FW-1:0] words [NB+NV], input bit gaps, input bit hold,
                          input bit flush_wait, input bit rst_wait,
                          input logic [FW-1:0] exp_res, input string tag);
    int p0 = en_pulses;
    for (int i = 0; i < NB + NV; i++) send(words[i], gaps ? int'($urandom_range(0, 2)) : 0);
    if (hold) in_data = 64'hDEAD_BEEF;
    else in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_en_after_last"}, compute_en, 1);
    @(posedge clk); #1;
    if (rst_wait) begin
      @(negedge clk);
      rstb = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstb = 1'b1;
      @(negedge clk);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_en"}, compute_en, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_result"}, result, 0);
      chk({tag, "_tau"}, tau_out, 0);
      chk({tag, "_vals"}, vals_out, 0);
      @(posedge clk); #1;
      return;
    end
    for (int t = 0; t < 3; t++) begin
      flush = flush_wait && (t == 0);
      @(posedge clk); #1;
      flush = 1'b0;
    end
    compute_result = mle();
    compute_ready = 1'b1;
    @(posedge clk); #1;
    compute_ready = 1'b0;
    compute_result = 64'h0BAD;
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_pulses"}, en_pulses - p0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_err;
`ifdef VERIFIER_IO_LOADER_RANGECHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_en", compute_en, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_banks", {tau_out, vals_out}, 0);
    @(posedge clk); #1;

    run_load('{64'd0, 64'd0, 64'd5, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 0, 64'd5, "tau0");
    run_load('{64'd1, 64'd1, 64'd5, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 0, 64'd11, "tau1");
    run_load('{64'd1, 64'd0, 64'd2, 64'd4, 64'd6, 64'd8}, 1, 1, 0, 0, 64'd4, "gaps");
    run_load('{64'd0, 64'd1, 64'd3, 64'd5, 64'd7, 64'd9}, 1, 1, 0, 0, 64'd7, "gaps2");

    send(64'd9, 0); send(64'd9, 0); send(64'd9, 0);
    flush = 1'b1; in_valid = 1'b1; in_data = 64'd77;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_stale_tau", tau_out, {64'd9, 64'd9});
    chk("flush_in_ready", in_ready, 1);
    @(posedge clk); #1;
    run_load('{64'd1, 64'd1, 64'd2, 64'd4, 64'd6, 64'd8}, 0, 0, 0, 0, 64'd8, "flush_reload");
    run_load('{64'd0, 64'd0, 64'd1, 64'd2, 64'd3, 64'd4}, 0, 0, 1, 0, 64'd1, "flush_wait");

    run_load('{64'd0, 64'd0, 64'd5, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 1, 64'd0, "rst_wait");
    run_load('{64'd0, 64'd0, 64'd5, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 0, 64'd5, "after_rst");

    run_load('{64'd0, 64'd0, Q + 64'd3, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 0, 64'd3, "range");
    chk("range_err", err, exp_err);
    run_load('{64'd1, 64'd1, 64'd5, 64'd7, 64'd9, 64'd11}, 0, 0, 0, 0, 64'd11, "range_next");
    chk("range_err_sticky", err, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
